rv_lsu: RTL

- Data-memory load/store unit between the execute stage and the writeback stage.
- Takes the execute-stage memory request (function code, address, store data) and runs a single-outstanding transaction on a ready-handshaked data bus.
- Returns raw load words plus load-done/store-done indications; writeback consumes these for lane extraction and stall release.
- Generates byte enables, replicates store data across lanes, and bounds bus waits with a timeout.

---
 rtl/rv_lsu.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rv_lsu.sv
// rv_lsu: data-memory load/store unit sitting between execute and writeback.
// Runs one outstanding transaction at a time on a ready-handshaked data bus,
// with byte-enable generation, store-lane replication and a bus-wait timeout.
// Optional misaligned-access trap: define URV_LSU_MISALIGN_EN.
//
// state | meaning
// IDLE  | waiting for an execute-stage load/store request
// BUS   | strobe asserted, waiting for dm_ready_i or timeout
// DONE  | done (and possibly error) reported, held until writeback advances
module rv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        w_stall_i,
  input  logic        x_valid_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic [2:0]  x_fun_i,
  input  logic [31:0] x_dm_addr_i,
  input  logic [31:0] x_dm_data_s_i,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_data_s_o,
  output logic [3:0]  dm_data_select_o,
  output logic        dm_load_o,
  output logic        dm_store_o,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_ready_i,
  output logic [31:0] wb_data_l_o,
  output logic        wb_load_done_o,
  output logic        wb_store_done_o,
  output logic        dm_bus_err_o,
  output logic        dm_misalign_o
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  // Counter value in the last BUS cycle before the timeout forces completion.
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          is_load_q;
  logic [3:0]    sel_d;
  logic [31:0]   data_s_d;
  logic          misalign;
  logic          start_bus, skip_bus, bus_ok, bus_to, leave_done;

  // Request decode: byte enables, store-lane replication and alignment check.
  always_comb begin
    sel_d    = 4'b0000;
    data_s_d = x_dm_data_s_i;
    misalign = 1'b0;
    case (x_fun_i)
      3'b000, 3'b100: sel_d = 4'b0001 << x_dm_addr_i[1:0];
      3'b001, 3'b101: sel_d = x_dm_addr_i[1] ? 4'b1100 : 4'b0011;
      3'b010:         sel_d = 4'b1111;
      default:        sel_d = 4'b0000;
    endcase
    case (x_fun_i[1:0])
      2'b00:   data_s_d = {4{x_dm_data_s_i[7:0]}};
      2'b01:   data_s_d = {2{x_dm_data_s_i[15:0]}};
      default: data_s_d = x_dm_data_s_i;
    endcase
`ifdef URV_LSU_MISALIGN_EN
    misalign = (((x_fun_i == 3'b001) || (x_fun_i == 3'b101)) && x_dm_addr_i[0]) ||
               ((x_fun_i == 3'b010) && (x_dm_addr_i[1:0] != 2'b00));
`endif
  end

  // Next-state logic; the event flags steer the registered datapath below.
  always_comb begin
    state_d    = state_q;
    start_bus  = 1'b0;
    skip_bus   = 1'b0;
    bus_ok     = 1'b0;
    bus_to     = 1'b0;
    leave_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (x_valid_i && (x_load_i || x_store_i)) begin
          // Invalid size codes and trapped misaligned accesses never touch the bus.
          if (misalign || (sel_d == 4'b0000)) begin
            skip_bus = 1'b1;
            state_d  = DONE;
          end else begin
            start_bus = 1'b1;
            state_d   = BUS;
          end
        end
      end
      BUS: begin
        // Ready wins over a timeout expiring in the same cycle.
        if (dm_ready_i) begin
          bus_ok  = 1'b1;
          state_d = DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
          bus_to  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!w_stall_i) begin
          leave_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Bus request registers, timeout counter and writeback result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dm_addr_o        <= '0;
      dm_data_s_o      <= '0;
      dm_data_select_o <= '0;
      dm_load_o        <= 1'b0;
      dm_store_o       <= 1'b0;
      wb_data_l_o      <= '0;
      wb_load_done_o   <= 1'b0;
      wb_store_done_o  <= 1'b0;
      dm_bus_err_o     <= 1'b0;
      is_load_q        <= 1'b0;
      cnt_q            <= '0;
    end else begin
      if (start_bus || skip_bus) begin
        dm_addr_o        <= {x_dm_addr_i[31:2], 2'b00};
        dm_data_s_o      <= data_s_d;
        dm_data_select_o <= sel_d;
        dm_load_o        <= start_bus & x_load_i;
        dm_store_o       <= start_bus & ~x_load_i;
        is_load_q        <= x_load_i;
        wb_data_l_o      <= '0;
        wb_load_done_o   <= skip_bus & x_load_i;
        wb_store_done_o  <= skip_bus & ~x_load_i;
        cnt_q            <= '0;
      end
      if (state_q == BUS && !bus_ok && !bus_to) cnt_q <= cnt_q + CW'(1);
      if (bus_ok || bus_to) begin
        dm_load_o       <= 1'b0;
        dm_store_o      <= 1'b0;
        wb_load_done_o  <= is_load_q;
        wb_store_done_o <= ~is_load_q;
        dm_bus_err_o    <= bus_to;
        wb_data_l_o     <= (bus_ok && is_load_q) ? dm_data_l_i : 32'd0;
      end
      if (leave_done) begin
        wb_load_done_o  <= 1'b0;
        wb_store_done_o <= 1'b0;
        dm_bus_err_o    <= 1'b0;
      end
    end
  end

`ifdef URV_LSU_MISALIGN_EN
  logic misalign_q;

  // Misalign flag lives for exactly the DONE residency of a trapped request.
  always_ff @(posedge clk_i) begin
    if (rst_i)                    misalign_q <= 1'b0;
    else if (skip_bus)            misalign_q <= misalign;
    else if (leave_done)          misalign_q <= 1'b0;
  end

  assign dm_misalign_o = misalign_q;
`else
  assign dm_misalign_o = 1'b0;
`endif

endmodule
